wishbone_target_arbiter: RTL

- Per-target arbitration stage placed directly downstream of the crossbar's address-decode fabric: N initiator ports contend for one Wishbone B4 pipelined target port.
- Round-robin grant, held for the whole bus cycle, extended across cycles while the owner holds LOCK.
- Tracks outstanding pipelined requests so that responses route back to the owning initiator and the owner is throttled at a fixed depth.

---
 rtl/wishbone_target_arbiter_if.sv | 64 ++++++
 rtl/wishbone_target_arbiter.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wishbone_target_arbiter_if.sv
`timescale 1ns/1ps
// wishbone_target_arbiter_if
// Bundles the signals between N Wishbone B4 pipelined initiators, the arbiter
// and one target. Initiator-side vectors are flat: initiator i owns bits
// [i*Width +: Width] of ADR_O, I_DAT_O, SEL_O and I_DAT_I.
//
// Modports:
//   slave  - arbiter view: takes initiator requests and target responses,
//            drives per-initiator responses, GNT and the target request.
//   master - environment view (initiators plus target): the mirror image.
//
// Handshake: a strobe is transferred on a cycle where STB is high and STALL
// is low; a response is one cycle of ACK, ERR or RTY, and the cycle ends
// when the initiator drops CYC.
interface wishbone_target_arbiter_if #(
  parameter int Initiators   = 2,
  parameter int AddressWidth = 16,
  parameter int DataWidth    = 8,
  parameter int SelWidth     = 1
);
  // Initiator requests
  logic [Initiators-1:0]              CYC_O;
  logic [Initiators-1:0]              STB_O;
  logic [Initiators-1:0]              WE_O;
  logic [Initiators-1:0]              LOCK_O;
  logic [Initiators*AddressWidth-1:0] ADR_O;
  logic [Initiators*DataWidth-1:0]    I_DAT_O;
  logic [Initiators*SelWidth-1:0]     SEL_O;
  // Responses back to initiators
  logic [Initiators*DataWidth-1:0]    I_DAT_I;
  logic [Initiators-1:0]              ACK_I;
  logic [Initiators-1:0]              ERR_I;
  logic [Initiators-1:0]              RTY_I;
  logic [Initiators-1:0]              STALL_I;
  logic [Initiators-1:0]              GNT;
  // Target request
  logic                               T_CYC_I;
  logic                               T_STB_I;
  logic                               T_WE_I;
  logic                               T_LOCK_I;
  logic [AddressWidth-1:0]            T_ADR_I;
  logic [DataWidth-1:0]               T_DAT_I;
  logic [SelWidth-1:0]                T_SEL_I;
  // Target response
  logic [DataWidth-1:0]               T_DAT_O;
  logic                               T_ACK_O;
  logic                               T_ERR_O;
  logic                               T_RTY_O;
  logic                               T_STALL_O;

  modport slave (
    input  CYC_O, STB_O, WE_O, LOCK_O, ADR_O, I_DAT_O, SEL_O,
    input  T_DAT_O, T_ACK_O, T_ERR_O, T_RTY_O, T_STALL_O,
    output I_DAT_I, ACK_I, ERR_I, RTY_I, STALL_I, GNT,
    output T_CYC_I, T_STB_I, T_WE_I, T_LOCK_I, T_ADR_I, T_DAT_I, T_SEL_I
  );

  modport master (
    output CYC_O, STB_O, WE_O, LOCK_O, ADR_O, I_DAT_O, SEL_O,
    output T_DAT_O, T_ACK_O, T_ERR_O, T_RTY_O, T_STALL_O,
    input  I_DAT_I, ACK_I, ERR_I, RTY_I, STALL_I, GNT,
    input  T_CYC_I, T_STB_I, T_WE_I, T_LOCK_I, T_ADR_I, T_DAT_I, T_SEL_I
  );
endinterface

// File: rtl/wishbone_target_arbiter.sv
`timescale 1ns/1ps
// wishbone_target_arbiter
// Per-target arbitration stage: N Wishbone B4 pipelined initiators contend
// for one target. Round-robin grant held for a whole bus cycle and across
// cycles while the owner holds LOCK. Outstanding strobes are counted so the
// owner is throttled at MaxOutstanding and responses with nothing pending
// are dropped.
//
// Ports:
//   CLK_I        clock
//   RST_I        synchronous active-high reset
//   bus          wishbone_target_arbiter_if.slave (initiator and target sides)
//   dbg_state_o  FSM state (0 IDLE, 1 OWNED, 2 LOCKHOLD)
//   dbg_count_o  outstanding-strobe counter
//
// Optional feature: define WB_ARB_TIMEOUT_EN to add a watchdog that, after
// TimeoutCycles cycles with strobes pending and no response, pulses ERR_I to
// the owner, drops T_CYC_I for that cycle and clears the counter.
module wishbone_target_arbiter #(
  parameter int Initiators     = 2,
  parameter int AddressWidth   = 16,
  parameter int DataWidth      = 8,
  parameter int SelWidth       = 1,
  parameter int MaxOutstanding = 4,
  parameter int TimeoutCycles  = 255
) (
  input  logic                                 CLK_I,
  input  logic                                 RST_I,
  wishbone_target_arbiter_if.slave             bus,
  output logic [1:0]                           dbg_state_o,
  output logic [$clog2(MaxOutstanding+1)-1:0]  dbg_count_o
);

  localparam int IdxW = (Initiators > 1) ? $clog2(Initiators) : 1;
  localparam int CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWNED    = 2'd1,
    LOCKHOLD = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [CntW-1:0] count_q, count_d;

  // Owner's request signals, selected by owner_q
  logic                    cyc_own, stb_own, we_own, lock_own;
  logic [AddressWidth-1:0] adr_own;
  logic [DataWidth-1:0]    dat_own;
  logic [SelWidth-1:0]     sel_own;

  always_comb begin
    cyc_own  = 1'b0;
    stb_own  = 1'b0;
    we_own   = 1'b0;
    lock_own = 1'b0;
    adr_own  = '0;
    dat_own  = '0;
    sel_own  = '0;
    for (int i = 0; i < Initiators; i++) begin
      if (owner_q == IdxW'(i)) begin
        cyc_own  = bus.CYC_O[i];
        stb_own  = bus.STB_O[i];
        we_own   = bus.WE_O[i];
        lock_own = bus.LOCK_O[i];
        adr_own  = bus.ADR_O[i*AddressWidth +: AddressWidth];
        dat_own  = bus.I_DAT_O[i*DataWidth +: DataWidth];
        sel_own  = bus.SEL_O[i*SelWidth +: SelWidth];
      end
    end
  end

  logic resp;
  assign resp = bus.T_ACK_O | bus.T_ERR_O | bus.T_RTY_O;

  logic timeout;
`ifdef WB_ARB_TIMEOUT_EN
  localparam int WdW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles + 1) : 1;
  logic [WdW-1:0] wd_q, wd_d;

  // Counts idle cycles with strobes pending; firing on TimeoutCycles-1 puts
  // the error pulse exactly TimeoutCycles cycles after the acceptance.
  always_comb begin
    timeout = 1'b0;
    wd_d    = '0;
    if (state_q == OWNED && cyc_own && count_q != '0 && !resp) begin
      if (wd_q == WdW'(TimeoutCycles - 1)) timeout = 1'b1;
      else                                 wd_d    = wd_q + WdW'(1);
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  assign timeout = 1'b0;
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TimeoutCycles != 0);
`endif

  // Round-robin pick: first requester searching upward from last_q+1
  logic [IdxW-1:0] pick;
  logic            found;
  int              cand;

  always_comb begin
    pick  = last_q;
    found = 1'b0;
    cand  = 0;
    for (int k = 1; k <= Initiators; k++) begin
      cand = int'(last_q) + k;
      if (cand >= Initiators) cand = cand - Initiators;
      if (!found && bus.CYC_O[IdxW'(cand)]) begin
        found = 1'b1;
        pick  = IdxW'(cand);
      end
    end
  end

  logic [Initiators-1:0]           gnt_v, ack_v, err_v, rty_v, stall_v;
  logic [Initiators*DataWidth-1:0] idat_v;
  logic                            t_cyc, t_stb, t_we, t_lock;
  logic [AddressWidth-1:0]         t_adr;
  logic [DataWidth-1:0]            t_dat;
  logic [SelWidth-1:0]             t_sel;
  logic                            full, accepted, resp_ok;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    last_d   = last_q;
    count_d  = count_q;
    gnt_v    = '0;
    ack_v    = '0;
    err_v    = '0;
    rty_v    = '0;
    stall_v  = '1;
    idat_v   = {Initiators{bus.T_DAT_O}};
    t_cyc    = 1'b0;
    t_stb    = 1'b0;
    t_we     = 1'b0;
    t_lock   = 1'b0;
    t_adr    = '0;
    t_dat    = '0;
    t_sel    = '0;
    full     = (count_q == CntW'(MaxOutstanding));
    accepted = 1'b0;
    resp_ok  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          owner_d = pick;
          count_d = '0;
          state_d = OWNED;
        end
      end

      OWNED: begin
        gnt_v[owner_q]   = 1'b1;
        t_cyc            = cyc_own & ~timeout;
        t_stb            = stb_own & ~full & ~timeout;
        t_we             = we_own;
        t_lock           = lock_own;
        t_adr            = adr_own;
        t_dat            = dat_own;
        t_sel            = sel_own;
        stall_v[owner_q] = bus.T_STALL_O | full | timeout;
        accepted         = t_stb & ~bus.T_STALL_O;
        // Responses with nothing pending are stray and never forwarded
        resp_ok          = resp & (count_q != '0);
        ack_v[owner_q]   = bus.T_ACK_O & resp_ok;
        err_v[owner_q]   = (bus.T_ERR_O & resp_ok) | timeout;
        rty_v[owner_q]   = bus.T_RTY_O & resp_ok;

        if (accepted && !resp_ok)      count_d = count_q + CntW'(1);
        else if (!accepted && resp_ok) count_d = count_q - CntW'(1);
        if (timeout)                   count_d = '0;

        if (!cyc_own) begin
          count_d = '0;
          if (lock_own) begin
            state_d = LOCKHOLD;
          end else begin
            state_d = IDLE;
            last_d  = owner_q;
          end
        end
      end

      LOCKHOLD: begin
        gnt_v[owner_q] = 1'b1;
        count_d        = '0;
        if (cyc_own) begin
          state_d = OWNED;
        end else if (!lock_own) begin
          state_d = IDLE;
          last_d  = owner_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset forces quiet outputs in the same cycle RST_I is seen
    if (RST_I) begin
      gnt_v   = '0;
      ack_v   = '0;
      err_v   = '0;
      rty_v   = '0;
      stall_v = '1;
      idat_v  = '0;
      t_cyc   = 1'b0;
      t_stb   = 1'b0;
      t_we    = 1'b0;
      t_lock  = 1'b0;
      t_adr   = '0;
      t_dat   = '0;
      t_sel   = '0;
    end
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IdxW'(Initiators - 1);
      count_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      count_q <= count_d;
    end
  end

  assign bus.GNT      = gnt_v;
  assign bus.ACK_I    = ack_v;
  assign bus.ERR_I    = err_v;
  assign bus.RTY_I    = rty_v;
  assign bus.STALL_I  = stall_v;
  assign bus.I_DAT_I  = idat_v;
  assign bus.T_CYC_I  = t_cyc;
  assign bus.T_STB_I  = t_stb;
  assign bus.T_WE_I   = t_we;
  assign bus.T_LOCK_I = t_lock;
  assign bus.T_ADR_I  = t_adr;
  assign bus.T_DAT_I  = t_dat;
  assign bus.T_SEL_I  = t_sel;

  assign dbg_state_o = state_q;
  assign dbg_count_o = count_q;

endmodule
